// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg : shared widths and FSM encoding for the ALU arbiter.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package alu_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage : alu_arbiter_pkg

`default_nettype wire

// File: rtl/alu_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker : combinational round-robin winner selection, scanning from ptr_i.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rr_picker
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  // Offset k visits requester (ptr+k) mod NREQ; the first valid one wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any_o && valid_i[i] && (((int'(ptr_i) + k) % NREQ) == i)) begin
          grant_o[i] = 1'b1;
          idx_o      = IDW'(i);
          any_o      = 1'b1;
        end
      end
    end
  end

endmodule : rr_picker

`default_nettype wire

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter : shares one combinational ALU between NREQ requesters (IDLE/EXEC/RESP).
// Optional macro ALU_ARBITER_STATS_EN adds saturating per-requester grant counters.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                   ALU_ARBITER_clk_xi,
  input  logic                   ALU_ARBITER_rst_xi,
  input  logic [NREQ-1:0]        ALU_ARBITER_req_valid_xi,
  output logic [NREQ-1:0]        ALU_ARBITER_req_ready_xo,
  input  logic [DATA_W*NREQ-1:0] ALU_ARBITER_req_A_xi,
  input  logic [DATA_W*NREQ-1:0] ALU_ARBITER_req_B_xi,
  input  logic [OP_W*NREQ-1:0]   ALU_ARBITER_req_OP_xi,
  output logic [DATA_W-1:0]      ALU_ARBITER_ALU_A_xo,
  output logic [DATA_W-1:0]      ALU_ARBITER_ALU_B_xo,
  output logic [OP_W-1:0]        ALU_ARBITER_ALU_OP_xo,
  input  logic [DATA_W-1:0]      ALU_ARBITER_ALU_F_xi,
  input  logic                   ALU_ARBITER_ALU_ZF_xi,
  input  logic                   ALU_ARBITER_ALU_OF_xi,
  output logic                   ALU_ARBITER_resp_valid_xo,
  input  logic                   ALU_ARBITER_resp_ready_xi,
  output logic [IDW-1:0]         ALU_ARBITER_resp_id_xo,
  output logic [DATA_W-1:0]      ALU_ARBITER_resp_F_xo,
  output logic                   ALU_ARBITER_resp_ZF_xo,
  output logic                   ALU_ARBITER_resp_OF_xo,
`ifdef ALU_ARBITER_STATS_EN
  output logic [CNT_W*NREQ-1:0]  ALU_ARBITER_grant_cnt_xo,
`endif
  output logic                   ALU_ARBITER_busy_xo
);

  state_e              state_q;
  logic [IDW-1:0]      ptr_q;
  logic [IDW-1:0]      ptr_d;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [OP_W-1:0]     op_q;
  logic [IDW-1:0]      id_q;
  logic [IDW-1:0]      resp_id_q;
  logic [DATA_W-1:0]   f_q;
  logic                zf_q;
  logic                of_q;

  logic [NREQ-1:0]     w_grant;
  logic [IDW-1:0]      w_win_idx;
  logic                w_any;
  logic                w_hs;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [OP_W-1:0]     w_sel_op;

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .valid_i (ALU_ARBITER_req_valid_xi),
    .ptr_i   (ptr_q),
    .grant_o (w_grant),
    .idx_o   (w_win_idx),
    .any_o   (w_any)
  );

  assign w_hs  = (state_q == ST_IDLE) && w_any;
  assign ptr_d = (w_win_idx == IDW'(NREQ - 1)) ? '0 : w_win_idx + IDW'(1);

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a  = ALU_ARBITER_req_A_xi[DATA_W*i +: DATA_W];
        w_sel_b  = ALU_ARBITER_req_B_xi[DATA_W*i +: DATA_W];
        w_sel_op = ALU_ARBITER_req_OP_xi[OP_W*i +: OP_W];
      end
    end
  end

  always_ff @(posedge ALU_ARBITER_clk_xi) begin
    if (ALU_ARBITER_rst_xi) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      id_q      <= '0;
      resp_id_q <= '0;
      f_q       <= '0;
      zf_q      <= 1'b0;
      of_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_any) begin
            a_q     <= w_sel_a;
            b_q     <= w_sel_b;
            op_q    <= w_sel_op;
            id_q    <= w_win_idx;
            ptr_q   <= ptr_d;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Response registers only change here, so they hold through RESP.
          resp_id_q <= id_q;
          f_q       <= ALU_ARBITER_ALU_F_xi;
          zf_q      <= ALU_ARBITER_ALU_ZF_xi;
          of_q      <= ALU_ARBITER_ALU_OF_xi;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          if (ALU_ARBITER_resp_ready_xi) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ALU_ARBITER_req_ready_xo  = (state_q == ST_IDLE) ? w_grant : '0;
  assign ALU_ARBITER_ALU_A_xo      = a_q;
  assign ALU_ARBITER_ALU_B_xo      = b_q;
  assign ALU_ARBITER_ALU_OP_xo     = op_q;
  assign ALU_ARBITER_resp_valid_xo = (state_q == ST_RESP);
  assign ALU_ARBITER_resp_id_xo    = resp_id_q;
  assign ALU_ARBITER_resp_F_xo     = f_q;
  assign ALU_ARBITER_resp_ZF_xo    = zf_q;
  assign ALU_ARBITER_resp_OF_xo    = of_q;
  assign ALU_ARBITER_busy_xo       = (state_q != ST_IDLE);

`ifdef ALU_ARBITER_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge ALU_ARBITER_clk_xi) begin
      if (ALU_ARBITER_rst_xi) begin
        cnt_q <= '0;
      end else if (w_hs && w_grant[g] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign ALU_ARBITER_grant_cnt_xo[CNT_W*g +: CNT_W] = cnt_q;
  end
`endif

endmodule : alu_arbiter

`default_nettype wire
